// File: rtl/mem_stage_if.sv
// Pipeline bundle types for the MEM stage and the data-memory req/ack bus
// that connects mem_stage (master) to its memory (slave).
package mem_stage_pkg;

  typedef struct packed {
    logic [31:0] aluresult;
    logic [31:0] writedata;
    logic [31:0] pcplus4;
    logic [4:0]  rd;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
  } ex_mem_t;

  typedef struct packed {
    logic [1:0]  resultsrc;
    logic [31:0] aluresult;
    logic [31:0] readdata;
    logic [31:0] pcplus4;
    logic [4:0]  rd;
    logic        regwrite;
  } mem_wb_t;

endpackage

interface mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [3:0]        dmem_wstrb;
  logic [31:0]       dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: issues data-memory loads/stores over req/ack, aligns and extends
// load data, stalls upstream while an access is outstanding, and registers MEM/WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter bit ALLOW_ZERO_WAIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  ex_mem_t            in,
  input  logic               in_valid,
  input  logic               flush,
  output logic               stall,
  output logic               misaligned,
  mem_stage_if.master        dmem,
  output mem_wb_t            out
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [1:0]  off;
  logic        memop;
  logic        misal;
  logic        done;
  logic        kill;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  mem_wb_t     out_next;

  assign off   = in.aluresult[1:0];
  assign memop = in_valid & (in.memread | in.memwrite) & ~flush;
  assign misal = ((in.funct3[1:0] == 2'b01) & off[0]) |
                 ((in.funct3[1:0] == 2'b10) & (off != 2'b00));
  assign kill  = ~in_valid | flush;

  // Once in WAIT the request is held regardless of flush; reset drops it at once.
  assign dmem.dmem_req  = rst_n & ((state == WAIT) | (memop & ~misal));
  assign dmem.dmem_we   = in.memwrite;
  assign dmem.dmem_addr = {in.aluresult[ADDR_W-1:2], 2'b00};

  assign done  = dmem.dmem_ack & ((state == WAIT) | ALLOW_ZERO_WAIT);
  assign stall = dmem.dmem_req & ~done;

  // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    dmem.dmem_wstrb = 4'b0000;
    dmem.dmem_wdata = in.writedata;
    if (in.memwrite) begin
      case (in.funct3[1:0])
        2'b00: begin
          dmem.dmem_wstrb = 4'b0001 << off;
          dmem.dmem_wdata = {4{in.writedata[7:0]}};
        end
        2'b01: begin
          dmem.dmem_wstrb = off[1] ? 4'b1100 : 4'b0011;
          dmem.dmem_wdata = {2{in.writedata[15:0]}};
        end
        2'b10:   dmem.dmem_wstrb = 4'b1111;
        default: dmem.dmem_wstrb = 4'b0000;
      endcase
    end
  end

  assign lane_b = dmem.dmem_rdata[{off, 3'b000} +: 8];
  assign lane_h = off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

  always_comb begin
    load_data = '0;
    case (in.funct3)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_data = {24'b0, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_data = {16'b0, lane_h};
      3'b010:  load_data = dmem.dmem_rdata;
      default: load_data = '0;
    endcase
  end

  // Stores and suppressed misaligned accesses never write the register file.
  always_comb begin
    out_next = '0;
    if (!kill) begin
      out_next.resultsrc = in.resultsrc;
      out_next.aluresult = in.aluresult;
      out_next.pcplus4   = in.pcplus4;
      out_next.rd        = in.rd;
      out_next.regwrite  = in.regwrite & ~in.memwrite & ~(memop & misal);
      if (in.memread & ~misal) out_next.readdata = load_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      out        <= '0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= memop & misal & ~stall;
      if (!stall) begin
        out   <= out_next;
        state <= IDLE;
      end else begin
        state <= WAIT;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage; one instance per ALLOW_ZERO_WAIT setting.
`timescale 1ns/1ps
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  ex_mem_t     in;
  logic        in_valid, flush, sel;
  logic [31:0] rdata;
  logic        ack;

  always #5 clk = ~clk;

  mem_stage_if #(.ADDR_W(32)) m0 ();
  mem_stage_if #(.ADDR_W(32)) m1 ();

  logic    stall0, stall1, mis0, mis1;
  mem_wb_t out0, out1;

  assign m0.dmem_rdata = rdata;
  assign m0.dmem_ack   = ack;
  assign m1.dmem_rdata = rdata;
  assign m1.dmem_ack   = ack;

  mem_stage #(.ADDR_W(32), .ALLOW_ZERO_WAIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid & ~sel), .flush(flush),
    .stall(stall0), .misaligned(mis0), .dmem(m0.master), .out(out0));

  mem_stage #(.ADDR_W(32), .ALLOW_ZERO_WAIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid & sel), .flush(flush),
    .stall(stall1), .misaligned(mis1), .dmem(m1.master), .out(out1));

  logic        stall_o, mis_o, req_o, we_o;
  logic [31:0] addr_o, wdata_o;
  logic [3:0]  strb_o;
  mem_wb_t     out_o;

  assign stall_o = sel ? stall1 : stall0;
  assign mis_o   = sel ? mis1 : mis0;
  assign out_o   = sel ? out1 : out0;
  assign req_o   = sel ? m1.dmem_req : m0.dmem_req;
  assign we_o    = sel ? m1.dmem_we : m0.dmem_we;
  assign addr_o  = sel ? m1.dmem_addr : m0.dmem_addr;
  assign wdata_o = sel ? m1.dmem_wdata : m0.dmem_wdata;
  assign strb_o  = sel ? m1.dmem_wstrb : m0.dmem_wstrb;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_mis(input ex_mem_t t);
    int sz = int'(t.funct3[1:0]);
    if (!(t.memread || t.memwrite) || sz == 3) return 1'b0;
    return (t.aluresult % (32'd1 << sz)) != 0;
  endfunction

  function automatic mem_wb_t model_out(input ex_mem_t t, input logic v, input logic fl,
                                        input logic [31:0] w);
    mem_wb_t     m = '0;
    logic [31:0] sh;
    int          off = int'(t.aluresult % 4);
    if (!v || fl) return m;
    m.resultsrc = t.resultsrc;
    m.aluresult = t.aluresult;
    m.pcplus4   = t.pcplus4;
    m.rd        = t.rd;
    m.regwrite  = t.regwrite && !t.memwrite && !is_mis(t);
    if (t.memread && !is_mis(t)) begin
      case (t.funct3)
        3'd0, 3'd4: begin
          sh = (w >> (8 * off)) & 32'hFF;
          m.readdata = (t.funct3 == 3'd0 && sh >= 128) ? sh - 32'd256 : sh;
        end
        3'd1, 3'd5: begin
          sh = (w >> (8 * off)) & 32'hFFFF;
          m.readdata = (t.funct3 == 3'd1 && sh >= 32768) ? sh - 32'd65536 : sh;
        end
        3'd2:    m.readdata = w;
        default: m.readdata = 32'd0;
      endcase
    end
    return m;
  endfunction

  task automatic exp_lanes(input ex_mem_t t, output logic [3:0] strb, output logic [31:0] wd);
    int off = int'(t.aluresult % 4);
    strb = 4'd0;
    wd   = t.writedata;
    if (t.memwrite) begin
      case (t.funct3[1:0])
        2'd0: begin strb = 4'(1 << off); wd = (t.writedata & 32'hFF) * 32'h0101_0101; end
        2'd1: begin strb = 4'(3 << off); wd = (t.writedata & 32'hFFFF) * 32'h0001_0001; end
        2'd2: strb = 4'hF;
        default: strb = 4'd0;
      endcase
    end
  endtask

  // fmode: 0 none, 1 flush raised from the second cycle on, 2 flush from the start
  task automatic run_op(input string tag, input ex_mem_t t, input logic v, input int dly,
                        input logic [31:0] w, input int fmode, input logic s);
    logic        memop_e, mis_e, fl_end, done;
    logic [3:0]  strb_e;
    logic [31:0] wd_e;
    int          stalls, exp_stalls, cyc;
    memop_e = v && (t.memread || t.memwrite) && (fmode != 2);
    mis_e   = is_mis(t);
    exp_lanes(t, strb_e, wd_e);
    exp_stalls = (!memop_e || mis_e) ? 0 : (s ? dly : (dly < 1 ? 1 : dly));
    stalls = 0; cyc = 0; done = 1'b0; fl_end = 1'b0;
    @(negedge clk);
    sel = s; in = t; in_valid = v; rdata = w; flush = (fmode == 2);
    while (!done && cyc < 20) begin
      ack = (cyc >= dly);
      if (fmode == 1 && cyc >= 1) flush = 1'b1;
      #1;
      check({tag, ".req"}, 128'(req_o), 128'(memop_e && !mis_e));
      if (req_o) begin
        check({tag, ".addr"}, 128'(addr_o), 128'(t.aluresult & 32'hFFFF_FFFC));
        check({tag, ".we"}, 128'(we_o), 128'(t.memwrite));
        check({tag, ".wstrb"}, 128'(strb_o), 128'(strb_e));
        if (t.memwrite) check({tag, ".wdata"}, 128'(wdata_o), 128'(wd_e));
      end
      if (stall_o) stalls++;
      else begin done = 1'b1; fl_end = flush; end
      cyc++;
      @(negedge clk);
    end
    if (!done) check({tag, ".timeout"}, 128'(0), 128'(1));
    in_valid = 1'b0; ack = 1'b0; flush = 1'b0;
    #1;
    check({tag, ".stalls"}, 128'(stalls), 128'(exp_stalls));
    check({tag, ".out"}, 128'(out_o), 128'(model_out(t, v, fl_end, w)));
    check({tag, ".misaligned"}, 128'(mis_o), 128'(memop_e && mis_e));
  endtask

  function automatic ex_mem_t mk(input logic [31:0] a, input logic [31:0] wd, input logic rdw,
                                 input logic mr, input logic mw, input logic [2:0] f3);
    ex_mem_t t;
    t.aluresult = a;   t.writedata = wd;  t.pcplus4 = 32'h0000_0404;
    t.rd        = 5'd5; t.regwrite = rdw; t.resultsrc = mr ? 2'b01 : 2'b00;
    t.memread   = mr;  t.memwrite  = mw;  t.funct3    = f3;
    return t;
  endfunction

  initial begin
    ex_mem_t t, add;
    int      kind, fm;
    in = mk(32'h100, 32'h0, 1'b1, 1'b1, 1'b0, 3'd2);
    in_valid = 1'b1; flush = 1'b0; sel = 1'b0; rdata = '0; ack = 1'b0;

    // Reset with a valid load pending: nothing may be requested.
    repeat (2) @(negedge clk);
    #1;
    check("rst.req0", 128'(m0.dmem_req), 128'(0));
    check("rst.req1", 128'(m1.dmem_req), 128'(0));
    check("rst.stall0", 128'(stall0), 128'(0));
    check("rst.stall1", 128'(stall1), 128'(0));
    check("rst.out0", 128'(out0), 128'(0));
    check("rst.out1", 128'(out1), 128'(0));
    check("rst.mis0", 128'(mis0), 128'(0));
    in_valid = 1'b0;
    rst_n = 1'b1;

    add = mk(32'h0000_1234, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0);
    run_op("add1", add, 1'b1, 0, 32'h0, 0, 1'b1);
    check("add1.rd", 128'(out_o.rd), 128'(5));
    run_op("add0", add, 1'b1, 0, 32'h0, 0, 1'b0);

    run_op("lb", mk(32'h103, 32'h0, 1'b1, 1'b1, 1'b0, 3'd0), 1'b1, 2, 32'h80FF_0000, 0, 1'b1);
    check("lb.const", 128'(out_o.readdata), 128'(32'hFFFF_FF80));
    run_op("lbu", mk(32'h103, 32'h0, 1'b1, 1'b1, 1'b0, 3'd4), 1'b1, 2, 32'h80FF_0000, 0, 1'b1);
    check("lbu.const", 128'(out_o.readdata), 128'(32'h0000_0080));

    run_op("sh", mk(32'h202, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 3'd1), 1'b1, 0, 32'h0, 0, 1'b1);
    check("sh.regwrite", 128'(out_o.regwrite), 128'(0));

    run_op("lw_mis", mk(32'h101, 32'h0, 1'b1, 1'b1, 1'b0, 3'd2), 1'b1, 0, 32'h1111_1111, 0, 1'b1);
    run_op("lw_flush", mk(32'h104, 32'h0, 1'b1, 1'b1, 1'b0, 3'd2), 1'b1, 3, 32'hCAFE_F00D, 1, 1'b1);
    check("lw_flush.regwrite", 128'(out_o.regwrite), 128'(0));

    run_op("lh_nzw", mk(32'h006, 32'h0, 1'b1, 1'b1, 1'b0, 3'd1), 1'b1, 0, 32'h8001_0000, 0, 1'b0);
    check("lh_nzw.const", 128'(out_o.readdata), 128'(32'hFFFF_8001));

    // Reset during WAIT abandons the access; a late ack afterwards is ignored.
    @(negedge clk);
    sel = 1'b1; in = mk(32'h108, 32'h0, 1'b1, 1'b1, 1'b0, 3'd2); in_valid = 1'b1; ack = 1'b0;
    #1;
    check("wrst.req_before", 128'(req_o), 128'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("wrst.req", 128'(req_o), 128'(0));
    check("wrst.stall", 128'(stall_o), 128'(0));
    @(negedge clk);
    #1;
    check("wrst.out", 128'(out_o), 128'(0));
    check("wrst.mis", 128'(mis_o), 128'(0));
    rst_n = 1'b1; in = add; ack = 1'b1;
    #1;
    check("wrst.idle_req", 128'(req_o), 128'(0));
    check("wrst.idle_stall", 128'(stall_o), 128'(0));
    @(negedge clk);
    #1;
    check("wrst.add_out", 128'(out_o), 128'(model_out(add, 1'b1, 1'b0, 32'h0)));
    in_valid = 1'b0; ack = 1'b0;

    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 2));
      t.aluresult = $urandom;
      t.writedata = $urandom;
      t.pcplus4   = $urandom;
      t.rd        = 5'($urandom);
      t.regwrite  = 1'($urandom);
      t.resultsrc = 2'($urandom);
      t.memread   = (kind == 1);
      t.memwrite  = (kind == 2);
      t.funct3    = (kind == 2) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      fm = int'($urandom_range(0, 9));
      fm = (fm == 0) ? 2 : (fm == 1) ? 1 : 0;
      run_op("rnd", t, ($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)), $urandom, fm,
             1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Pipeline MEM stage and MEM/WB register. It consumes the EX/MEM bundle and performs data-memory loads and stores over a req/ack handshake. Load data is aligned and sign/zero-extended here. It stalls the upstream pipeline while memory is outstanding and registers a mem_wb_t bundle that wb_stage consumes directly.

Parameters:
ADDR_W, 32, data-memory byte address width
ALLOW_ZERO_WAIT, 1, 1: an ack in the same cycle as the request completes with no stall; 0: every access stalls at least one cycle

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
in  input  ex_mem_t  EX/MEM bundle: aluresult[31:0], writedata[31:0], pcplus4[31:0], rd[4:0], regwrite, resultsrc[1:0], memread, memwrite, funct3[2:0]
in_valid  input  1  bundle holds a real instruction
flush  input  1  discard current instruction; insert bubble
stall  output  1  hold EX/MEM and all earlier stages this cycle
misaligned  output  1  one-cycle pulse: misaligned access was suppressed
dmem_req  output  1  memory request valid
dmem_we  output  1  1 = store
dmem_addr  output  ADDR_W  word-aligned address, {aluresult[ADDR_W-1:2],2'b00}
dmem_wdata  output  32  store data, lane-shifted
dmem_wstrb  output  4  byte enables
dmem_rdata  input  32  load word; valid with dmem_ack
dmem_ack  input  1  request accepted and completed
out  output  mem_wb_t  registered: resultsrc, aluresult, readdata, pcplus4, rd, regwrite

Behaviour:
- Definitions: memop = in_valid & (memread | memwrite) & ~flush; off = aluresult[1:0].
- Misalignment: halfword with off[0]=1, or word with off!=0. No request is issued and stall is not asserted. Next cycle: out.regwrite=0 and misaligned=1 for one cycle.
- FSM states:
  - IDLE: dmem_req = memop & ~misal.
    - Ack in the same cycle with ALLOW_ZERO_WAIT=1: complete, stay IDLE.
    - Otherwise: stall=1 and go to WAIT.
  - WAIT: dmem_req=1; addr, we, wdata and wstrb held constant from unchanged `in`; stall=1 until dmem_ack. On ack: stall=0, capture, go to IDLE.
- Store lanes (funct3):
  - SB: wstrb = 1<<off; wdata = {4{wd[7:0]}}.
  - SH: wstrb = 0011 or 1100; wdata = {2{wd[15:0]}}.
  - SW: wstrb = 1111; wdata = wd.
  - Loads: wstrb = 0000.
- Load extract from dmem_rdata at ack:
  - LB/LBU: byte at off, sign/zero-extended.
  - LH/LHU: halfword at off[1], sign/zero-extended.
  - LW: full word.
  - funct3 011/110/111: readdata = 0.
- Output register updates when stall=0:
  - Non-memory valid instruction: out latched next edge (1-cycle latency); readdata = 0.
  - Load: readdata = extracted data.
  - Store: regwrite forced 0.
  - in_valid=0 or flush: bubble (out.regwrite=0, all other fields 0).
  - While stall=1: out holds its value; the bubble is inserted on the completing edge only.
- Flush in WAIT: ignored until ack (the access is never cancelled mid-flight); the flushed instruction then writes a bubble.
- Reset (rst_n=0 at clk edge): state=IDLE, out all zeros, misaligned=0.
  - Outputs while rst_n=0: dmem_req=0, stall=0.
  - Reset during WAIT abandons the access; a late ack after reset in IDLE with no request is ignored.
- dmem_ack while dmem_req=0 is ignored.

Test Plan:
- ADD result 0x0000_1234, rd=5, regwrite=1, in_valid=1 -> next cycle out.aluresult=0x1234, rd=5, regwrite=1; stall never high.
- LB addr 0x103, dmem_rdata=0x80FF_0000, ack 2 cycles after req -> stall high 2 cycles; dmem_addr=0x100; out.readdata=0xFFFF_FF80. LBU same access -> 0x0000_0080.
- SH addr 0x202, writedata=0xDEAD_BEEF, zero-wait ack -> dmem_we=1, wstrb=1100, wdata=0xBEEF_BEEF; stall=0; out.regwrite=0.
- LW addr 0x101 -> dmem_req never asserted; next cycle misaligned=1, out.regwrite=0.
- LW in WAIT: assert flush, then ack -> out is a bubble (regwrite=0). Repeat with rst_n=0 during WAIT -> dmem_req=0, out zeros, state IDLE.
- LH addr 0x006, rdata=0x8001_0000, ack same cycle with ALLOW_ZERO_WAIT=0 -> stall asserted 1 cycle, readdata=0xFFFF_8001.
